// File: rtl/overflow_monitor.sv
// overflow_monitor: watches an upstream 4-bit counter for F->0 wraps, counts
// them while armed, queues {wrap count, timestamp} events in a small FIFO and
// raises an alarm when the wrap count reaches a programmable threshold.
module overflow_monitor #(
  parameter int EVT_W = 8,
  parameter int TS_W  = 16,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             arm,
  input  logic             clear,
  input  logic [3:0]       count_in,
  input  logic             overflow_in,
  input  logic [EVT_W-1:0] threshold,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [EVT_W-1:0] evt_wraps,
  output logic [TS_W-1:0]  evt_stamp,
  output logic             alarm,
  output logic             ovf_seen,
  output logic [3:0]       drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, ALARM} state_t;

  state_t           state_reg;
  logic             alarm_reg;
  logic [TS_W-1:0]  ts_reg;
  logic [3:0]       prev_q_reg;
  logic             prev_valid_reg;
  logic             ovf_q_reg;
  logic             ovf_seen_reg;
  logic [EVT_W-1:0] wrap_cnt_reg;
  logic [EVT_W-1:0] wrap_cnt_next;
  logic [3:0]       drop_cnt_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW:0]      occ_reg;

  logic [EVT_W-1:0] wraps_mem [DEPTH];
  logic [TS_W-1:0]  stamp_mem [DEPTH];

  logic wrap_det;
  logic push;
  logic hit;
  logic full;
  logic pop;
  logic push_acc;
  logic drop;

  // Wrap detection and FIFO handshake decisions for this edge. clear wins
  // over everything, so it suppresses both the push and the pop.
  always_comb begin
    wrap_det      = prev_valid_reg && (prev_q_reg == 4'hF) && (count_in == 4'h0);
    push          = wrap_det && (state_reg != IDLE) && !clear;
    wrap_cnt_next = (wrap_cnt_reg == '1) ? wrap_cnt_reg : wrap_cnt_reg + EVT_W'(1);
    hit           = push && (threshold != '0) && (wrap_cnt_next == threshold);
    full          = (occ_reg == (AW+1)'(DEPTH));
    pop           = (occ_reg != '0) && evt_ready && !clear;
    // A full FIFO can still take the push when the head leaves on the same edge.
    push_acc      = push && (!full || pop);
    drop          = push && full && !pop;
  end

  // Free-running timestamp and upstream counter history; clear does not touch these.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_reg         <= '0;
      prev_q_reg     <= '0;
      prev_valid_reg <= 1'b0;
      ovf_q_reg      <= 1'b0;
    end else begin
      ts_reg         <= ts_reg + TS_W'(1);
      prev_q_reg     <= count_in;
      prev_valid_reg <= 1'b1;
      ovf_q_reg      <= overflow_in;
    end
  end

  // Sticky overflow flag, set on a rising edge of overflow_in.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_seen_reg <= 1'b0;
    end else if (clear) begin
      ovf_seen_reg <= 1'b0;
    end else if (overflow_in && !ovf_q_reg) begin
      ovf_seen_reg <= 1'b1;
    end
  end

  // Monitor FSM with the wrap counter and a registered alarm output.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      alarm_reg    <= 1'b0;
      wrap_cnt_reg <= '0;
    end else if (clear) begin
      state_reg    <= IDLE;
      alarm_reg    <= 1'b0;
      wrap_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arm) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (push) begin
            wrap_cnt_reg <= wrap_cnt_next;
          end
          if (hit) begin
            state_reg <= ALARM;
            alarm_reg <= 1'b1;
          end
        end
        ALARM: begin
          if (push) begin
            wrap_cnt_reg <= wrap_cnt_next;
          end
        end
        default: begin
          state_reg <= IDLE;
          alarm_reg <= 1'b0;
        end
      endcase
    end
  end

  // Drop counter: saturates at 15 so a long stall cannot wrap it back to small values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_cnt_reg <= '0;
    end else if (clear) begin
      drop_cnt_reg <= '0;
    end else if (drop && (drop_cnt_reg != 4'hF)) begin
      drop_cnt_reg <= drop_cnt_reg + 4'd1;
    end
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      occ_reg    <= '0;
    end else if (clear) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push_acc) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (push_acc && !pop) begin
        occ_reg <= occ_reg + (AW+1)'(1);
      end else if (pop && !push_acc) begin
        occ_reg <= occ_reg - (AW+1)'(1);
      end
    end
  end

  // Event storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (push_acc) begin
      wraps_mem[wr_ptr_reg] <= wrap_cnt_next;
      stamp_mem[wr_ptr_reg] <= ts_reg;
    end
  end

  assign evt_valid = (occ_reg != '0);
  assign evt_wraps = wraps_mem[rd_ptr_reg];
  assign evt_stamp = stamp_mem[rd_ptr_reg];
  assign alarm     = alarm_reg;
  assign ovf_seen  = ovf_seen_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_overflow_monitor.sv
// Testbench for overflow_monitor: directed scenarios followed by randomized
// traffic, every cycle compared against an event-level reference model.
module tb_overflow_monitor;

  localparam int EVT_W = 8;
  localparam int TS_W  = 16;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             arm;
  logic             clear;
  logic [3:0]       count_in;
  logic             overflow_in;
  logic [EVT_W-1:0] threshold;
  logic             evt_valid;
  logic             evt_ready;
  logic [EVT_W-1:0] evt_wraps;
  logic [TS_W-1:0]  evt_stamp;
  logic             alarm;
  logic             ovf_seen;
  logic [3:0]       drop_cnt;

  overflow_monitor #(.EVT_W(EVT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .arm(arm), .clear(clear),
    .count_in(count_in), .overflow_in(overflow_in), .threshold(threshold),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_wraps(evt_wraps),
    .evt_stamp(evt_stamp), .alarm(alarm), .ovf_seen(ovf_seen), .drop_cnt(drop_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of pending events plus plain integer bookkeeping.
  typedef struct { int wraps; int stamp; } ev_t;
  ev_t m_q[$];
  int  m_time;        // cycles since reset release, modulo 2^TS_W
  int  m_last_count;  // -1 until a count has been observed after reset
  bit  m_last_ovf;
  bit  m_ovf_seen;
  bit  m_armed;       // monitoring active (RUN or ALARM)
  bit  m_alarmed;
  int  m_wraps;
  int  m_drops;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_time = 0; m_last_count = -1; m_last_ovf = 0; m_ovf_seen = 0;
    m_armed = 0; m_alarmed = 0; m_wraps = 0; m_drops = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit wrapped;
    bit was_armed;
    ev_t e;
    wrapped   = (m_last_count == 15) && (count_in == 4'h0);
    was_armed = m_armed;
    if (clear) begin
      m_q.delete();
      m_wraps = 0; m_drops = 0; m_ovf_seen = 0;
      m_armed = 0; m_alarmed = 0;
    end else begin
      if (overflow_in && !m_last_ovf) m_ovf_seen = 1;
      if (evt_ready && m_q.size() > 0) begin
        e = m_q.pop_front();
        $display("evt pop  wraps=%0d stamp=%0d", e.wraps, e.stamp);
      end
      if (was_armed && wrapped) begin
        if (m_wraps < (1 << EVT_W) - 1) m_wraps++;
        if (m_q.size() < DEPTH) begin
          e.wraps = m_wraps; e.stamp = m_time;
          m_q.push_back(e);
        end else if (m_drops < 15) begin
          m_drops++;
        end
        if (!m_alarmed && threshold != 0 && m_wraps == int'(threshold)) m_alarmed = 1;
      end
      if (!was_armed && arm) m_armed = 1;
    end
    m_time       = (m_time + 1) % (1 << TS_W);
    m_last_count = int'(count_in);
    m_last_ovf   = overflow_in;
  endtask

  task automatic compare_all(input string where);
    check({where, ":evt_valid"}, 32'(evt_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check({where, ":evt_wraps"}, 32'(evt_wraps), 32'(m_q[0].wraps));
      check({where, ":evt_stamp"}, 32'(evt_stamp), 32'(m_q[0].stamp));
    end
    check({where, ":alarm"},    32'(alarm),    32'(m_alarmed));
    check({where, ":ovf_seen"}, 32'(ovf_seen), 32'(m_ovf_seen));
    check({where, ":drop_cnt"}, 32'(drop_cnt), 32'(m_drops));
  endtask

  // One clock: model predicts, DUT samples, outputs compared 1 ns later.
  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    compare_all("cyc");
    @(negedge clock);
  endtask

  // Count 0..F then 0; the final step is the wrap edge.
  task automatic sweep(input bit rdy_at_wrap, input bit clr_at_wrap);
    bit saved;
    for (int i = 0; i < 16; i++) begin
      count_in = 4'(i);
      step();
    end
    saved     = evt_ready;
    count_in  = 4'h0;
    if (rdy_at_wrap) evt_ready = 1'b1;
    clear     = clr_at_wrap;
    step();
    clear     = 1'b0;
    evt_ready = saved;
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    #1 reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; arm = 1'b0; clear = 1'b0; count_in = 4'h0;
    overflow_in = 1'b0; threshold = '0; evt_ready = 1'b0;
    model_reset();
    #1;
    compare_all("reset");
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Three wraps with threshold 3, consumer always ready.
    arm = 1'b1; threshold = 8'd3; evt_ready = 1'b1;
    repeat (3) sweep(1'b0, 1'b0);
    check("alarm_after_thr", 32'(alarm), 32'd1);

    // Stalled consumer: six wraps into a four-deep FIFO.
    clear = 1'b1; step(); clear = 1'b0;
    threshold = 8'd0; evt_ready = 1'b0;
    repeat (6) sweep(1'b0, 1'b0);
    check("drop_after_6", 32'(drop_cnt), 32'd2);
    check("head_held", 32'(evt_wraps), 32'd1);
    evt_ready = 1'b1;
    repeat (5) step();
    check("drained", 32'(evt_valid), 32'd0);

    // Refill, then push and pop on the same edge while full.
    evt_ready = 1'b0;
    repeat (4) sweep(1'b0, 1'b0);
    sweep(1'b1, 1'b0);
    check("full_pushpop_drop", 32'(drop_cnt), 32'd2);

    // Reach ALARM, then clear on the same edge as a wrap.
    clear = 1'b1; step(); clear = 1'b0;
    threshold = 8'd2; evt_ready = 1'b0;
    repeat (2) sweep(1'b0, 1'b0);
    sweep(1'b0, 1'b1);
    check("clear_alarm", 32'(alarm), 32'd0);
    check("clear_valid", 32'(evt_valid), 32'd0);

    // Disarmed: wraps ignored, overflow still observed.
    arm = 1'b0; step();
    sweep(1'b0, 1'b0);
    overflow_in = 1'b1; step();
    check("ovf_idle", 32'(ovf_seen), 32'd1);
    overflow_in = 1'b0;

    // Asynchronous reset with three events queued.
    clear = 1'b1; step(); clear = 1'b0;
    arm = 1'b1; threshold = 8'd0;
    repeat (3) sweep(1'b0, 1'b0);
    reset_pulse();
    count_in = 4'h0; step();
    repeat (2) sweep(1'b0, 1'b0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      case ($urandom_range(0, 3))
        0:       count_in = 4'hF;
        1:       count_in = 4'h0;
        default: count_in = 4'($urandom_range(0, 15));
      endcase
      evt_ready = ($urandom_range(0, 2) != 0);
      arm       = ($urandom_range(0, 7) != 0);
      clear     = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) overflow_in = ~overflow_in;
      if ($urandom_range(0, 49) == 0) threshold = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 699) == 0) reset_pulse();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/overflow_monitor.md
OVERFLOW_MONITOR -- requirements
Module: overflow_monitor

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- EVT_W, 8, wrap-counter and threshold width
- TS_W, 16, timestamp width
- DEPTH, 4, event FIFO entries; power of two, 2 or more
REQ-002 SHALL have ports (name, direction, width, meaning):
- clock  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset
- arm  input  1  level; starts monitoring from IDLE
- clear  input  1  synchronous flush/restart
- count_in  input  4  count from the upstream 4-bit counter
- overflow_in  input  1  sticky overflow flag from the upstream counter
- threshold  input  EVT_W  alarm level; 0 disables the alarm
- evt_valid  output  1  FIFO head valid
- evt_ready  input  1  consumer accepts the head
- evt_wraps  output  EVT_W  wrap count recorded with the head event
- evt_stamp  output  TS_W  timestamp recorded with the head event
- alarm  output  1  high in ALARM state
- ovf_seen  output  1  sticky; set on a rising edge of overflow_in
- drop_cnt  output  4  events lost because the FIFO was full; saturating

Function
REQ-003 SHALL keep a free-running TS_W-bit timestamp counter that increments every cycle and wraps from all-ones to 0.
REQ-004 SHALL register count_in as prev_q every cycle. It SHALL set prev_valid 1 cycle after reset is released.
REQ-005 SHALL detect a wrap on the edge where prev_valid=1, prev_q=4'hF and count_in=4'h0. Other transitions, including F->F and F->nonzero, are not wraps.
REQ-006 SHALL set ovf_seen on the edge where overflow_in=1 and its registered copy is 0. Only reset or clear clears ovf_seen.
REQ-007 SHALL implement the state machine IDLE, RUN, ALARM:
- IDLE -> RUN when arm=1.
- RUN -> ALARM on the edge where the updated wrap count equals threshold and threshold is not 0.
- ALARM -> IDLE only on clear.
REQ-008 SHALL ignore wraps in IDLE: no count and no event.
REQ-009 In RUN and ALARM, each wrap SHALL increment wrap_cnt by 1. wrap_cnt SHALL saturate at 2^EVT_W-1.
REQ-010 Each wrap in RUN or ALARM SHALL push {updated wrap_cnt, timestamp value before that edge's increment} into the FIFO.
REQ-011 SHALL drive alarm=1 exactly while in ALARM. The transition cycle counts, so alarm is high the cycle after the threshold wrap.
REQ-012 SHALL assert evt_valid exactly when the FIFO is non-empty. A push into an empty FIFO SHALL show evt_valid=1 and its data the cycle after the wrap edge.
REQ-013 SHALL pop the head on an edge with evt_valid=1 and evt_ready=1. evt_wraps and evt_stamp SHALL stay stable while evt_valid=1 and evt_ready=0.
REQ-014 SHALL preserve event order (FIFO) with no bubbles.
REQ-015 When full with no pop on the same edge, a push SHALL be dropped. drop_cnt SHALL then increment, saturating at 15, and the FIFO contents SHALL stay unchanged.
REQ-016 When full with a pop on the same edge, a push SHALL be accepted and occupancy SHALL stay DEPTH.
REQ-017 When empty, a simultaneous push and evt_ready SHALL only push. No pop occurs because evt_valid was 0.
REQ-018 clear=1 SHALL take priority over everything else on that edge:
- flush the FIFO
- zero wrap_cnt, drop_cnt and ovf_seen
- go to IDLE
- discard any wrap on the same edge
clear SHALL NOT reset the timestamp, prev_q or prev_valid.
REQ-019 A threshold change SHALL take effect at the next compare. A threshold at or below a wrap_cnt already reached SHALL NOT trigger ALARM. Only equality on an increment triggers it.

Reset
REQ-020 When reset=0, SHALL immediately force all of the following, regardless of clock:
- state IDLE
- timestamp, wrap_cnt, prev_q, prev_valid, overflow_in registered copy, ovf_seen and drop_cnt all 0
- FIFO empty, so evt_valid=0
- alarm=0
REQ-021 SHALL remove the reset asynchronously, with the first state update on the first rising clock edge where reset=1.
REQ-022 Reset asserted mid-operation SHALL discard all FIFO contents and any in-flight wrap.

Verification
REQ-023 Scenario: arm=1, threshold=3, count_in sweeps 0..F,0 three times, evt_ready=1 -> three events with evt_wraps 1,2,3 and increasing evt_stamp; alarm=1 the cycle after the third wrap.
REQ-024 Scenario: state RUN, evt_ready=0, six wraps with DEPTH=4 -> evt_wraps 1..4 held, drop_cnt=2; then evt_ready=1 -> pops 1,2,3,4 in order, then evt_valid=0.
REQ-025 Scenario: FIFO full, a wrap and evt_ready=1 on the same edge -> occupancy stays 4, drop_cnt unchanged, new tail evt_wraps=5.
REQ-026 Scenario: state ALARM, clear=1 on the same edge as a wrap -> next cycle IDLE, alarm=0, evt_valid=0, drop_cnt=0, the wrap is not counted.
REQ-027 Scenario: arm=0, count_in F->0 -> no event. overflow_in 0->1 -> ovf_seen=1 next cycle, even in IDLE.
REQ-028 Scenario: reset pulsed low between clock edges with 3 events queued -> evt_valid=0 and alarm=0 immediately; first wrap detection is possible only after prev_valid=1.
